i2s_transmitter: RTL and testbench



---
 rtl/i2s_transmitter_pkg.sv | 13 +
 rtl/i2s_transmitter_fifo.sv | 65 ++++++
 rtl/i2s_transmitter.sv | 153 +++++++++++++++
 tb/tb_i2s_transmitter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_transmitter_pkg.sv
// Shared constants and helpers for the I2S/TDM transmitter.
// I2S_MODE_* select the framing used by the serialiser.
package i2s_transmitter_pkg;

   localparam int I2S_MODE_I2S = 0;
   localparam int I2S_MODE_LJ  = 1;

   // Counter/pointer width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_transmitter_fifo.sv
// First-word-fall-through frame FIFO: o_rdata shows the head entry while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module i2s_transmitter_fifo
   import i2s_transmitter_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int SIZE  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_write,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_read,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = clog2_min1(SIZE);
   localparam int CW = $clog2(SIZE + 1);

   logic [WIDTH-1:0] r_mem [SIZE];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(SIZE - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(SIZE));
   assign w_pop   = i_read && !o_empty;
   assign w_push  = i_write && (!o_full || w_pop);
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S / left-justified / TDM transmitter: frame FIFO feeding a BCLK-divided serialiser.
// All serial state moves on BCLK falling edges; enable low parks the serial side at reset values.
module i2s_transmitter
   import i2s_transmitter_pkg::*;
#(
   parameter int DATA_W            = 24,
   parameter int SLOT_W            = 25,
   parameter int CHANNELS          = 2,
   parameter int DIV               = 25,
   parameter int FIFO_DEPTH        = 8,
   parameter int MODE              = 0,
   parameter int HOLD_ON_UNDERFLOW = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [CHANNELS*DATA_W-1:0]   frame_in,
   input  logic                         write_frame,
   output logic                         full,
   output logic                         bclk,
   output logic                         lrclk,
   output logic                         sdata,
   output logic                         underflow,
   output logic [15:0]                  underflow_count
);

   localparam int FRAME_W = CHANNELS * DATA_W;
   localparam int SW      = clog2_min1(CHANNELS);
   localparam int BW      = clog2_min1(SLOT_W);
   localparam int DW      = clog2_min1(DIV);

   logic [DW-1:0]      r_div;
   logic               r_bclk;
   logic               r_lrclk;
   logic [SW-1:0]      r_slot;
   logic [BW-1:0]      r_bit;
   logic [SLOT_W:0]    r_shift;
   logic [FRAME_W-1:0] r_frame;
   logic               r_underflow;
   logic [15:0]        r_uf_count;

   logic               w_tick;
   logic               w_fall;
   logic               w_frame_start;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_uf_event;
   logic [FRAME_W-1:0] w_fifo_data;
   logic [FRAME_W-1:0] w_frame_next;
   logic [FRAME_W-1:0] w_frame_cur;
   logic [SLOT_W-1:0]  w_slot_word;

   // Channel sample left-aligned in its slot, padding bits zero.
   function automatic logic [SLOT_W-1:0] slot_word(input logic [FRAME_W-1:0] frame,
                                                   input logic [SW-1:0]      slot);
      logic [DATA_W-1:0] sample;
      sample = frame[(CHANNELS - 1 - int'(slot)) * DATA_W +: DATA_W];
      return SLOT_W'(sample) << (SLOT_W - DATA_W);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   i2s_transmitter_fifo #(
      .WIDTH (FRAME_W),
      .SIZE  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_write (write_frame),
      .i_wdata (frame_in),
      .i_read  (w_pop),
      .o_rdata (w_fifo_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_tick        = enable && (r_div == DW'(DIV - 1));
   assign w_fall        = w_tick && r_bclk;
   assign w_frame_start = w_fall && (r_slot == '0) && (r_bit == '0);
   assign w_pop         = w_frame_start && !w_empty;
   assign w_uf_event    = w_frame_start && w_empty;

   always_comb begin
      w_frame_next = '0;
      if (!w_empty) begin
         w_frame_next = w_fifo_data;
      end else if (HOLD_ON_UNDERFLOW != 0) begin
         w_frame_next = r_frame;
      end
   end

   // The slot loaded at k = 0 must come from the frame being popped this same edge.
   assign w_frame_cur = w_frame_start ? w_frame_next : r_frame;
   assign w_slot_word = slot_word(w_frame_cur, r_slot);

   // r_shift[SLOT_W-1] is the left-justified bit; r_shift[SLOT_W] is that bit one BCLK later.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_div   <= '0;
         r_bclk  <= 1'b0;
         r_slot  <= '0;
         r_bit   <= '0;
         r_lrclk <= 1'b0;
         r_shift <= '0;
         r_frame <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            r_bclk <= ~r_bclk;
         end
         if (w_fall) begin
            if (w_frame_start) begin
               r_frame <= w_frame_next;
            end
            r_lrclk <= (int'(r_slot) >= CHANNELS / 2);
            if (r_bit == '0) begin
               r_shift <= {r_shift[SLOT_W-1], w_slot_word};
            end else begin
               r_shift <= {r_shift[SLOT_W-1:0], 1'b0};
            end
            if (r_bit == BW'(SLOT_W - 1)) begin
               r_bit  <= '0;
               r_slot <= (r_slot == SW'(CHANNELS - 1)) ? '0 : r_slot + 1'b1;
            end else begin
               r_bit <= r_bit + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_underflow <= 1'b0;
         r_uf_count  <= '0;
      end else begin
         r_underflow <= w_uf_event;
         if (w_uf_event) begin
            r_uf_count <= sat_inc16(r_uf_count);
         end
      end
   end

   assign full            = w_full;
   assign bclk            = r_bclk;
   assign lrclk           = r_lrclk;
   assign sdata           = (MODE == I2S_MODE_LJ) ? r_shift[SLOT_W-1] : r_shift[SLOT_W];
   assign underflow       = r_underflow;
   assign underflow_count = r_uf_count;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench: four transmitter instances (LJ, I2S, TDM, hold-on-underflow) on shared controls.
// Serial bits are captured on every BCLK falling edge and compared with hand-derived words.
module tb_i2s_transmitter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr;
   logic [7:0]  fin8;
   logic [15:0] fin16;

   logic [3:0]  w_bclk, w_sd, w_lr, w_uf, w_full;
   logic [15:0] w_cnt [4];

   logic [3:0]  r_prev = 4'b0;
   bit          sd_mem [4][4096];
   bit          lr_mem [4][4096];
   int          nrec [4] = '{0, 0, 0, 0};
   int          nuf  [4] = '{0, 0, 0, 0};

   int          n_total = 0;
   int          n_bad   = 0;
   int          base;
   int          uf_base;

   always #5 clk = ~clk;

   // 0: left-justified, 1: I2S, 2: 4-channel TDM, 3: left-justified with hold-on-underflow
   i2s_transmitter #(.DATA_W(4), .SLOT_W(6), .CHANNELS(2), .DIV(2), .FIFO_DEPTH(8),
                     .MODE(1), .HOLD_ON_UNDERFLOW(0)) dut_lj (
      .clk(clk), .reset(rst), .enable(en), .frame_in(fin8), .write_frame(wr),
      .full(w_full[0]), .bclk(w_bclk[0]), .lrclk(w_lr[0]), .sdata(w_sd[0]),
      .underflow(w_uf[0]), .underflow_count(w_cnt[0]));

   i2s_transmitter #(.DATA_W(4), .SLOT_W(6), .CHANNELS(2), .DIV(2), .FIFO_DEPTH(8),
                     .MODE(0), .HOLD_ON_UNDERFLOW(0)) dut_i2s (
      .clk(clk), .reset(rst), .enable(en), .frame_in(fin8), .write_frame(wr),
      .full(w_full[1]), .bclk(w_bclk[1]), .lrclk(w_lr[1]), .sdata(w_sd[1]),
      .underflow(w_uf[1]), .underflow_count(w_cnt[1]));

   i2s_transmitter #(.DATA_W(4), .SLOT_W(4), .CHANNELS(4), .DIV(2), .FIFO_DEPTH(8),
                     .MODE(1), .HOLD_ON_UNDERFLOW(0)) dut_tdm (
      .clk(clk), .reset(rst), .enable(en), .frame_in(fin16), .write_frame(wr),
      .full(w_full[2]), .bclk(w_bclk[2]), .lrclk(w_lr[2]), .sdata(w_sd[2]),
      .underflow(w_uf[2]), .underflow_count(w_cnt[2]));

   i2s_transmitter #(.DATA_W(4), .SLOT_W(6), .CHANNELS(2), .DIV(2), .FIFO_DEPTH(8),
                     .MODE(1), .HOLD_ON_UNDERFLOW(1)) dut_hold (
      .clk(clk), .reset(rst), .enable(en), .frame_in(fin8), .write_frame(wr),
      .full(w_full[3]), .bclk(w_bclk[3]), .lrclk(w_lr[3]), .sdata(w_sd[3]),
      .underflow(w_uf[3]), .underflow_count(w_cnt[3]));

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (r_prev[i] && !w_bclk[i] && nrec[i] < 4096) begin
            sd_mem[i][nrec[i]] = w_sd[i];
            lr_mem[i][nrec[i]] = w_lr[i];
            nrec[i]++;
         end
         if (w_uf[i]) nuf[i]++;
      end
      r_prev = w_bclk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sd_bits(input int i, input int b, input int n);
      logic [63:0] r = '0;
      for (int j = 0; j < n; j++) r = {r[62:0], 1'(sd_mem[i][b+j])};
      return r;
   endfunction

   function automatic logic [63:0] lr_bits(input int i, input int b, input int n);
      logic [63:0] r = '0;
      for (int j = 0; j < n; j++) r = {r[62:0], 1'(lr_mem[i][b+j])};
      return r;
   endfunction

   task automatic wait_rec(input int i, input int target);
      for (int t = 0; t < 5000 && nrec[i] < target; t++) @(negedge clk);
      check("rec_count", 64'(nrec[i]), 64'(target));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; wr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] f8, input logic [15:0] f16);
      @(posedge clk); #1;
      fin8 = f8; fin16 = f16; wr = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic start();
      @(posedge clk); #1;
      en = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wr = 1'b0; fin8 = '0; fin16 = '0;

      // reset values
      do_reset();
      check("rst_bclk",  64'(w_bclk[0]), 64'd0);
      check("rst_lrclk", 64'(w_lr[0]),   64'd0);
      check("rst_sdata", 64'(w_sd[0]),   64'd0);
      check("rst_full",  64'(w_full[0]), 64'd0);
      check("rst_uf",    64'(w_uf[0]),   64'd0);
      check("rst_cnt",   64'(w_cnt[0]),  64'd0);

      // one A5 frame: LJ, I2S, and hold-on-underflow repeating it
      do_reset();
      push(8'hA5, 16'h0000);
      base = nrec[0];
      start();
      wait_rec(0, base + 36);
      check("lj_frame",    sd_bits(0, base, 12), 64'hA14);
      check("lj_lrclk",    lr_bits(0, base, 12), 64'h03F);
      check("lj_zeros",    sd_bits(0, base + 12, 24), 64'h0);
      check("i2s_frame",   sd_bits(1, base, 12), 64'h50A);
      check("i2s_lrclk",   lr_bits(1, base, 12), 64'h03F);
      check("i2s_zeros",   sd_bits(1, base + 12, 24), 64'h0);
      check("hold_frames", sd_bits(3, base, 36), 64'hA14A14A14);
      check("lj_cnt",      64'(w_cnt[0]), 64'd2);
      check("hold_cnt",    64'(w_cnt[3]), 64'd2);

      // TDM 4 channels, 16'h1234
      do_reset();
      push(8'h00, 16'h1234);
      base = nrec[2];
      start();
      wait_rec(2, base + 16);
      check("tdm_frame", sd_bits(2, base, 16), 64'h1234);
      check("tdm_lrclk", lr_bits(2, base, 16), 64'h00FF);
      check("tdm_cnt",   64'(w_cnt[2]), 64'd0);

      // empty FIFO for three frames; a write during reset is dropped
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; fin8 = 8'hFF; wr = 1'b1;
      @(posedge clk); #1;
      wr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      base = nrec[0];
      uf_base = nuf[0];
      start();
      wait_rec(0, base + 36);
      check("empty_bits",   sd_bits(0, base, 36), 64'h0);
      check("empty_pulses", 64'(nuf[0] - uf_base), 64'd3);
      check("empty_cnt",    64'(w_cnt[0]), 64'd3);

      // overfill with enable low, then drain in order
      do_reset();
      for (int n = 1; n <= 9; n++) begin
         push(8'(n), 16'(n));
         if (n == 7) check("full_at7", 64'(w_full[0]), 64'd0);
         if (n == 8) check("full_at8", 64'(w_full[0]), 64'd1);
      end
      check("full_after9",  64'(w_full[0]), 64'd1);
      check("full_tdm",     64'(w_full[2]), 64'd1);
      check("full_hold",    64'(w_full[3]), 64'd1);
      base = nrec[0];
      start();
      wait_rec(0, base + 108);
      for (int n = 1; n <= 8; n++) begin
         check($sformatf("fifo_frame%0d", n), sd_bits(0, base + 12 * (n - 1), 12), 64'(n << 2));
      end
      check("fifo_frame9", sd_bits(0, base + 96, 12), 64'h0);
      check("fifo_cnt",    64'(w_cnt[0]), 64'd1);
      check("fifo_full",   64'(w_full[0]), 64'd0);

      // reset mid-frame with four frames queued
      do_reset();
      for (int n = 0; n < 4; n++) push(8'(8'h11 * (n + 1)), 16'h0);
      base = nrec[0];
      start();
      wait_rec(0, base + 4);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_bclk",  64'(w_bclk[0]), 64'd0);
      check("mid_rst_lrclk", 64'(w_lr[0]),   64'd0);
      check("mid_rst_sdata", 64'(w_sd[0]),   64'd0);
      check("mid_rst_uf",    64'(w_uf[0]),   64'd0);
      check("mid_rst_cnt",   64'(w_cnt[0]),  64'd0);
      rst = 1'b0;
      base = nrec[0];
      wait_rec(0, base + 12);
      check("mid_rst_empty", sd_bits(0, base, 12), 64'h0);
      check("mid_rst_cnt2",  64'(w_cnt[0]), 64'd1);

      // enable dropped mid-frame keeps the FIFO and restarts at k = 0
      do_reset();
      push(8'hA5, 16'h0);
      push(8'h3C, 16'h0);
      base = nrec[0];
      start();
      wait_rec(0, base + 4);
      en = 1'b0;
      push(8'h7E, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      check("en_off_bclk",  64'(w_bclk[0]), 64'd0);
      check("en_off_lrclk", 64'(w_lr[0]),   64'd0);
      check("en_off_sdata", 64'(w_sd[0]),   64'd0);
      base = nrec[0];
      start();
      wait_rec(0, base + 36);
      check("en_frame_3C", sd_bits(0, base, 12), 64'h330);
      check("en_frame_7E", sd_bits(0, base + 12, 12), 64'h738);
      check("en_frame_uf", sd_bits(0, base + 24, 12), 64'h0);
      check("en_cnt",      64'(w_cnt[0]), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
